// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic processing-element slice:
// mode encodings, FSM state type, default widths and a saturating adder.
package systolic_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int ACC_WIDTH_DEF  = 32;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'b00,
    MODE_LOAD   = 2'b01,
    MODE_WS     = 2'b10,
    MODE_OS     = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOADING,
    ST_WS,
    ST_OS,
    ST_OS_DRAIN
  } pe_state_e;

  typedef struct packed {
    logic [63:0] sum;
    logic        ovf;
  } sat_res_t;

  // Operands are sign-extended w-bit values carried in 64 bits (w <= 63);
  // the result is clamped to the signed w-bit range.
  function automatic sat_res_t sat_add(input logic signed [63:0] a,
                                       input logic signed [63:0] b,
                                       input int unsigned        w);
    logic signed [64:0] s, hi, lo;
    sat_res_t r;
    s  = {a[63], a} + {b[63], b};
    hi = (65'sd1 <<< (w - 1)) - 65'sd1;
    lo = -(65'sd1 <<< (w - 1));
    if (s > hi) begin
      r.sum = hi[63:0];
      r.ovf = 1'b1;
    end else if (s < lo) begin
      r.sum = lo[63:0];
      r.ovf = 1'b1;
    end else begin
      r.sum = s[63:0];
      r.ovf = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/pe_mac.sv
// Combinational signed multiply followed by a saturating add; shared by the
// weight-stationary and output-stationary datapaths.
module pe_mac
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) (
  input  logic signed [DATA_WIDTH-1:0] a_i,
  input  logic signed [DATA_WIDTH-1:0] b_i,
  input  logic signed [ACC_WIDTH-1:0]  addend_i,
  output logic        [ACC_WIDTH-1:0]  sum_o,
  output logic                         ovf_o
);

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [63:0]             prod_x, add_x;
  sat_res_t                       res;
  logic                           unused_hi;

  assign prod   = a_i * b_i;
  assign prod_x = {{(64-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
  assign add_x  = {{(64-ACC_WIDTH){addend_i[ACC_WIDTH-1]}}, addend_i};
  assign res    = sat_add(prod_x, add_x, ACC_WIDTH);

  assign sum_o     = res.sum[ACC_WIDTH-1:0];
  assign ovf_o     = res.ovf;
  assign unused_hi = ^res.sum[63:ACC_WIDTH];

endmodule

// File: rtl/proc_elem_param.sv
// Systolic-array processing element: bypass, weight load, weight-stationary
// MAC and output-stationary accumulate/drain, with a sticky saturation flag.
module proc_elem_param
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            mode,
  input  logic [ACC_WIDTH-1:0]  in_top,
  input  logic                  in_top_valid,
  input  logic [DATA_WIDTH-1:0] in_left,
  input  logic                  in_left_valid,
  input  logic                  drain,
  input  logic                  acc_clear,
  output logic [ACC_WIDTH-1:0]  out_down,
  output logic                  out_down_valid,
  output logic [DATA_WIDTH-1:0] out_right,
  output logic                  out_right_valid,
  output logic                  weight_loaded,
  output logic                  overflow
);

  pe_state_e             state_q, state_d;
  logic [ACC_WIDTH-1:0]  out_down_q, out_down_d;
  logic                  odv_q, odv_d;
  logic [DATA_WIDTH-1:0] out_right_q;
  logic                  orv_q;
  logic [DATA_WIDTH-1:0] weight_q, weight_d;
  logic                  wl_q, wl_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic                  ovf_q, ovf_d;

  logic signed [DATA_WIDTH-1:0] mac_a, mac_b;
  logic signed [ACC_WIDTH-1:0]  mac_add;
  logic        [ACC_WIDTH-1:0]  mac_sum;
  logic                         mac_ovf;
  logic                         pair;
  logic                         unused_state;

  // One MAC serves both paths; the active mode steers its operands.
  pe_mac #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_mac (
    .a_i      (mac_a),
    .b_i      (mac_b),
    .addend_i (mac_add),
    .sum_o    (mac_sum),
    .ovf_o    (mac_ovf)
  );

  assign pair = in_left_valid & in_top_valid;

  always_comb begin
    state_d    = ST_IDLE;
    out_down_d = out_down_q;
    odv_d      = 1'b0;
    weight_d   = weight_q;
    wl_d       = wl_q;
    acc_d      = acc_q;
    ovf_d      = ovf_q;
    mac_a      = '0;
    mac_b      = '0;
    mac_add    = '0;
    case (mode_e'(mode))
      MODE_BYPASS: begin
        state_d    = ST_IDLE;
        out_down_d = in_top;
        odv_d      = in_top_valid;
      end
      MODE_LOAD: begin
        state_d = ST_LOADING;
        if (in_top_valid) begin
          weight_d = in_top[DATA_WIDTH-1:0];
          wl_d     = 1'b1;
        end
      end
      MODE_WS: begin
        state_d = ST_WS;
        mac_a   = wl_q ? weight_q : '0;
        mac_b   = in_left;
        mac_add = in_top_valid ? in_top : '0;
        if (in_left_valid) begin
          out_down_d = mac_sum;
          odv_d      = 1'b1;
          ovf_d      = ovf_q | mac_ovf;
        end
      end
      MODE_OS: begin
        mac_a   = in_left;
        mac_b   = in_top[DATA_WIDTH-1:0];
        // A drain restarts the sum, so the same-cycle pair lands on zero.
        mac_add = drain ? '0 : acc_q;
        if (drain) begin
          state_d    = ST_OS_DRAIN;
          out_down_d = acc_q;
          odv_d      = 1'b1;
          acc_d      = pair ? mac_sum : '0;
        end else begin
          state_d    = ST_OS;
          out_down_d = in_top;
          odv_d      = in_top_valid;
          if (pair) begin
            acc_d = mac_sum;
            ovf_d = ovf_q | mac_ovf;
          end
        end
      end
      default: ;
    endcase
    if (acc_clear) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      out_down_q  <= '0;
      odv_q       <= 1'b0;
      out_right_q <= '0;
      orv_q       <= 1'b0;
      weight_q    <= '0;
      wl_q        <= 1'b0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_down_q  <= out_down_d;
      odv_q       <= odv_d;
      out_right_q <= in_left;
      orv_q       <= in_left_valid;
      weight_q    <= weight_d;
      wl_q        <= wl_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
    end
  end

  // Mode decode is combinational; the registered state is kept for observability.
  assign unused_state = ^state_q;

  assign out_down        = out_down_q;
  assign out_down_valid  = odv_q;
  assign out_right       = out_right_q;
  assign out_right_valid = orv_q;
  assign weight_loaded   = wl_q;
  assign overflow        = ovf_q;

endmodule

// File: tb/tb_proc_elem_param.sv
// Directed and randomized checks of proc_elem_param against an arithmetic
// reference model of the processing element.
module tb_proc_elem_param;

  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mode;
  logic [31:0] in_top;
  logic        in_top_valid;
  logic [15:0] in_left;
  logic        in_left_valid;
  logic        drain;
  logic        acc_clear;
  logic [31:0] out_down;
  logic        out_down_valid;
  logic [15:0] out_right;
  logic        out_right_valid;
  logic        weight_loaded;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  logic [31:0] e_od;
  logic        e_odv;
  logic [15:0] e_or;
  logic        e_orv;
  longint      m_w;
  logic        m_wl;
  longint      m_acc;
  logic        m_ovf;

  always #5 clk = ~clk;

  proc_elem_param dut (
    .clk             (clk),
    .reset           (reset),
    .mode            (mode),
    .in_top          (in_top),
    .in_top_valid    (in_top_valid),
    .in_left         (in_left),
    .in_left_valid   (in_left_valid),
    .drain           (drain),
    .acc_clear       (acc_clear),
    .out_down        (out_down),
    .out_down_valid  (out_down_valid),
    .out_right       (out_right),
    .out_right_valid (out_right_valid),
    .weight_loaded   (weight_loaded),
    .overflow        (overflow)
  );

  function automatic longint clamp(input longint s);
    if (s > MAXV) return MAXV;
    if (s < MINV) return MINV;
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of the PE behaviour, evaluated from the inputs present at the edge.
  task automatic model_edge();
    longint l, t, p, s;
    if (reset) begin
      e_od = '0; e_odv = 0; e_or = '0; e_orv = 0;
      m_w = 0; m_wl = 0; m_acc = 0; m_ovf = 0;
      return;
    end
    e_or  = in_left;
    e_orv = in_left_valid;
    l = longint'($signed(in_left));
    case (mode)
      2'b00: begin
        e_od  = in_top;
        e_odv = in_top_valid;
      end
      2'b01: begin
        e_odv = 0;
        if (in_top_valid) begin
          m_w  = longint'($signed(in_top[15:0]));
          m_wl = 1;
        end
      end
      2'b10: begin
        if (in_left_valid) begin
          t = in_top_valid ? longint'($signed(in_top)) : 0;
          s = t + (m_wl ? m_w : 0) * l;
          if (s != clamp(s)) m_ovf = 1;
          e_od  = 32'(clamp(s));
          e_odv = 1;
        end else e_odv = 0;
      end
      default: begin
        p = l * longint'($signed(in_top[15:0]));
        if (drain) begin
          e_od  = 32'(m_acc);
          e_odv = 1;
          m_acc = (in_left_valid && in_top_valid) ? p : 0;
        end else begin
          e_od  = in_top;
          e_odv = in_top_valid;
          if (in_left_valid && in_top_valid) begin
            s = m_acc + p;
            if (s != clamp(s)) m_ovf = 1;
            m_acc = clamp(s);
          end
        end
      end
    endcase
    if (acc_clear) begin
      m_acc = 0;
      m_ovf = 0;
    end
  endtask

  task automatic step(input logic rst, input logic [1:0] md, input logic [31:0] top,
                      input logic tv, input logic [15:0] left, input logic lv,
                      input logic dr, input logic clr, input string tag);
    reset = rst; mode = md; in_top = top; in_top_valid = tv;
    in_left = left; in_left_valid = lv; drain = dr; acc_clear = clr;
    @(posedge clk);
    model_edge();
    #1;
    chk({tag, "/od"},  out_down, e_od);
    chk({tag, "/odv"}, 32'(out_down_valid), 32'(e_odv));
    chk({tag, "/or"},  32'(out_right), 32'(e_or));
    chk({tag, "/orv"}, 32'(out_right_valid), 32'(e_orv));
    chk({tag, "/wl"},  32'(weight_loaded), 32'(m_wl));
    chk({tag, "/ovf"}, 32'(overflow), 32'(m_ovf));
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] top;
    logic [15:0] left;
    reset = 1; mode = 0; in_top = 0; in_top_valid = 0;
    in_left = 0; in_left_valid = 0; drain = 0; acc_clear = 0;
    @(negedge clk);
    step(1, 2'b00, 0, 0, 0, 0, 0, 0, "init");

    // Disturb state, then reset: everything returns to zero.
    step(0, 2'b01, 32'd7, 1, 16'd9, 1, 0, 0, "pre_ld");
    step(0, 2'b10, 32'd3, 1, 16'd4, 1, 0, 0, "pre_ws");
    step(1, 2'b10, 32'd3, 1, 16'd4, 1, 0, 0, "rst");
    chk("rst_od", out_down, 32'd0);
    chk("rst_odv", 32'(out_down_valid), 32'd0);
    chk("rst_or", 32'(out_right), 32'd0);
    chk("rst_wl", 32'(weight_loaded), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);

    // Weight-stationary basic MAC.
    step(0, 2'b01, 32'd3, 1, 16'd0, 0, 0, 0, "ld3");
    chk("ld3_odv", 32'(out_down_valid), 32'd0);
    step(0, 2'b10, 32'd10, 1, 16'd5, 1, 0, 0, "ws25");
    chk("ws25_od", out_down, 32'd25);
    chk("ws25_odv", 32'(out_down_valid), 32'd1);
    chk("ws25_or", 32'(out_right), 32'd5);
    step(0, 2'b10, 32'd10, 1, 16'd5, 0, 1, 0, "ws_hold");
    chk("ws_hold_od", out_down, 32'd25);

    // Positive saturation, sticky until acc_clear.
    step(0, 2'b01, 32'h7FFF, 1, 16'd0, 0, 0, 0, "ld_max");
    step(0, 2'b10, 32'h7FFFFFFF, 1, 16'h7FFF, 1, 0, 0, "ws_sat");
    chk("ws_sat_od", out_down, 32'h7FFFFFFF);
    chk("ws_sat_ovf", 32'(overflow), 32'd1);
    step(0, 2'b00, 32'd1, 1, 16'd0, 0, 0, 0, "byp");
    chk("ovf_sticky", 32'(overflow), 32'd1);
    step(0, 2'b00, 32'd2, 0, 16'd0, 0, 0, 1, "clr");
    chk("ovf_clr", 32'(overflow), 32'd0);

    // Output-stationary accumulate and drain.
    step(0, 2'b11, 32'd2, 1, 16'd1, 1, 0, 0, "os1");
    step(0, 2'b11, 32'd4, 1, 16'd3, 1, 0, 0, "os2");
    step(0, 2'b11, 32'd6, 1, 16'd5, 1, 0, 0, "os3");
    step(0, 2'b11, 32'd8, 1, 16'd7, 1, 0, 0, "os4");
    chk("os_fwd_od", out_down, 32'd8);
    step(0, 2'b11, 32'd0, 0, 16'd0, 0, 1, 0, "dr100");
    chk("dr100_od", out_down, 32'd100);
    chk("dr100_odv", 32'(out_down_valid), 32'd1);
    step(0, 2'b11, 32'd0, 0, 16'd0, 0, 0, 0, "after_dr");
    chk("dr_one_cycle", 32'(out_down_valid), 32'd0);
    step(0, 2'b11, 32'd0, 0, 16'd0, 0, 1, 0, "dr0");
    chk("dr0_od", out_down, 32'd0);

    // Drain with a same-cycle pair restarts the sum at that product.
    step(0, 2'b11, 32'd2, 1, 16'd1, 1, 0, 0, "os5");
    step(0, 2'b11, 32'd4, 1, 16'd3, 1, 0, 0, "os6");
    step(0, 2'b11, 32'd6, 1, 16'd5, 1, 0, 0, "os7");
    step(0, 2'b11, 32'd8, 1, 16'd7, 1, 0, 0, "os8");
    step(0, 2'b11, 32'd3, 1, 16'd2, 1, 1, 0, "drp");
    chk("drp_od", out_down, 32'd100);
    step(0, 2'b11, 32'd0, 0, 16'd0, 0, 1, 0, "dr6");
    chk("dr6_od", out_down, 32'd6);

    // Reset mid-drain discards the accumulator.
    step(0, 2'b11, 32'd10, 1, 16'd4, 1, 0, 0, "os40");
    step(1, 2'b11, 32'd0, 0, 16'd0, 0, 1, 0, "rst_os");
    chk("rst_os_odv", 32'(out_down_valid), 32'd0);
    step(0, 2'b11, 32'd0, 0, 16'd0, 0, 1, 0, "dr_rst");
    chk("dr_rst_od", out_down, 32'd0);
    chk("dr_rst_odv", 32'(out_down_valid), 32'd1);

    // acc_clear with drain still shows the pre-clear sum.
    step(0, 2'b11, 32'd5, 1, 16'd5, 1, 0, 0, "os25");
    step(0, 2'b11, 32'd0, 0, 16'd0, 0, 1, 1, "drclr");
    chk("drclr_od", out_down, 32'd25);
    step(0, 2'b11, 32'd0, 0, 16'd0, 0, 1, 0, "drclr2");
    chk("drclr2_od", out_down, 32'd0);

    // Accumulator survives mode changes; drain ignored outside OS.
    step(0, 2'b11, 32'd3, 1, 16'd3, 1, 0, 0, "os9");
    step(0, 2'b00, 32'd77, 1, 16'd0, 0, 1, 0, "byp_dr");
    chk("byp_dr_od", out_down, 32'd77);
    step(0, 2'b01, 32'd2, 1, 16'd0, 0, 1, 0, "ld_dr");
    step(0, 2'b10, 32'd1, 1, 16'd6, 1, 1, 0, "ws_dr");
    chk("ws_dr_od", out_down, 32'd13);
    step(0, 2'b11, 32'd0, 0, 16'd0, 0, 1, 0, "dr9");
    chk("dr9_od", out_down, 32'd9);

    // Randomized traffic with extreme operands to provoke saturation.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: top = $urandom;
        1: top = 32'h7FFFFFFF;
        2: top = 32'hFFFF8000;
        default: top = 32'h00007FFF;
      endcase
      case ($urandom_range(0, 2))
        0: left = 16'($urandom);
        1: left = 16'h7FFF;
        default: left = 16'h8000;
      endcase
      step(($urandom_range(0, 39) == 0), 2'($urandom_range(0, 3)), top,
           ($urandom_range(0, 3) != 0), left, ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 11) == 0), "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/proc_elem_param.md
PROC_ELEM_PARAM -- requirements
Module: proc_elem_param

Interface
REQ-001 Parameters SHALL be:
- DATA_WIDTH, 16, signed operand width.
- ACC_WIDTH, 32, signed partial-sum/accumulator width, >= 2*DATA_WIDTH.
REQ-002 Ports SHALL be:
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- mode  in  2  operating mode: 00 BYPASS, 01 LOAD, 10 WS_MAC, 11 OS_ACC.
- in_top  in  ACC_WIDTH  vertical input: partial sum (WS), weight (LOAD, low DATA_WIDTH bits), B operand (OS, low DATA_WIDTH bits).
- in_top_valid  in  1  in_top qualifier.
- in_left  in  DATA_WIDTH  horizontal activation operand.
- in_left_valid  in  1  in_left qualifier.
- drain  in  1  OS mode: emit accumulator on out_down.
- acc_clear  in  1  zero the accumulator and the overflow flag.
- out_down  out  ACC_WIDTH  registered vertical output.
- out_down_valid  out  1  out_down qualifier.
- out_right  out  DATA_WIDTH  registered copy of in_left.
- out_right_valid  out  1  registered copy of in_left_valid.
- weight_loaded  out  1  stored weight is valid.
- overflow  out  1  sticky saturation flag.

Function
REQ-003 Arithmetic SHALL be two's-complement signed.
- Product: DATA_WIDTH x DATA_WIDTH -> 2*DATA_WIDTH, sign-extended to ACC_WIDTH.
- Every add SHALL saturate to the ACC_WIDTH signed range and set overflow on saturation.
REQ-004 out_right/out_right_valid SHALL equal in_left/in_left_valid delayed by exactly one cycle, in every mode.
REQ-005 LOAD: when in_top_valid=1, weight <= in_top[DATA_WIDTH-1:0] and weight_loaded <= 1.
- out_down_valid SHALL be 0 in LOAD.
- Without in_top_valid, weight SHALL be unchanged.
REQ-006 WS_MAC: when in_left_valid=1, next cycle out_down = sat(top_term + weight*in_left) and out_down_valid=1.
- top_term = in_top when in_top_valid=1, else 0.
- When in_left_valid=0, out_down_valid=0 and out_down holds.
- Latency: 1 cycle.
REQ-007 WS_MAC with weight_loaded=0 SHALL use weight 0, so out_down = top_term.
REQ-008 OS_ACC: when in_left_valid=1 and in_top_valid=1, acc <= sat(acc + in_left*in_top[DATA_WIDTH-1:0]).
- Next cycle out_down SHALL carry in_top and out_down_valid SHALL equal in_top_valid (operand forwarding).
REQ-009 OS_ACC drain=1: next cycle out_down = acc (pre-update value), out_down_valid=1.
- Forwarding is suppressed that cycle.
- acc SHALL become the product of any same-cycle valid pair, else 0.
REQ-010 BYPASS: next cycle out_down = in_top and out_down_valid = in_top_valid.
- acc and weight SHALL be held.
REQ-011 acc_clear=1 SHALL zero acc and overflow next cycle.
- Priority: reset > acc_clear > drain > accumulate.
- If acc_clear and drain are both 1, out_down SHALL still carry the pre-clear acc.
REQ-012 Internal FSM SHALL have states IDLE, LOADING, WS, OS, OS_DRAIN.
- State SHALL be selected from mode each cycle.
- OS_DRAIN SHALL last exactly one cycle per drain pulse.
- OS_DRAIN returns to OS, or to IDLE/LOADING/WS if mode changed.
- Any mode change SHALL take effect the cycle it is applied.
- acc and weight SHALL be preserved across mode changes.
REQ-013 drain outside OS_ACC SHALL be ignored.
REQ-014 Saturation SHALL clamp to 0x7FF..F / 0x800..0 of ACC_WIDTH, never wrap.

Reset
REQ-015 On reset, the following SHALL be 0 after the next rising edge: out_down, out_down_valid, out_right, out_right_valid, weight, weight_loaded, acc, overflow.
- FSM SHALL go to IDLE.
REQ-016 Reset asserted mid-accumulation or mid-drain SHALL discard the in-flight result; no valid output SHALL appear in the following cycle.

Structure
REQ-017 A shared package systolic_pkg SHALL hold:
- mode encodings and the FSM state type;
- a saturating-add helper;
- default DATA_WIDTH/ACC_WIDTH constants.
REQ-018 One sub-module pe_mac SHALL implement combinational signed multiply plus saturating add with an overflow output.
- It is reused by the WS and OS paths.

Verification (DATA_WIDTH=16, ACC_WIDTH=32)
REQ-019 Reset: any prior state, reset for 1 cycle -> every output 0 next cycle.
REQ-020 LOAD weight 3, then WS_MAC with in_left=5, in_top=10 (both valid) -> next cycle out_down=25, valid=1, out_right=5.
REQ-021 Saturation: WS, weight=0x7FFF, in_left=0x7FFF, in_top=0x7FFFFFFF -> out_down=0x7FFFFFFF, overflow=1 (sticky until acc_clear).
REQ-022 OS_ACC: pairs (1,2),(3,4),(5,6),(7,8), then drain -> out_down=100 with valid for exactly one cycle; acc=0 afterwards.
REQ-023 OS_ACC with acc=100: drain together with pair (2,3) -> out_down=100; a subsequent drain -> out_down=6.
REQ-024 Reset mid-OS (acc=40) -> acc=0, out_down_valid=0 next cycle; the following drain -> out_down=0.
